jk_excitation_gen: RTL and testbench

Drives the J/K inputs of a downstream JK flip-flop so that its output follows a buffered stream of target bits; it is the inverse of our JK-from-D block, turning a D-style "next value" stream into JK excitation codes. Target bits enter through a valid/ready handshake into a small FIFO and are issued one per cycle as registered {j,k} codes. A shadow model of the flop's state is kept and compared against the flop's actual q, which is fed back into the block, to flag and count mismatches.

---
 rtl/jk_excitation_gen.sv | 157 +++++++++++++++
 tb/tb_jk_excitation_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_gen.sv
// jk_excitation_gen
//
// Turns a stream of target bits ("what q should be next") into J/K excitation
// codes for a downstream JK flip-flop. Target bits are buffered in a small
// FIFO and issued one per cycle as registered {j,k}. A shadow copy of the
// flop state is kept. Delayed through a two-stage pipeline, it is compared
// against the flop's real q to flag and count mismatches.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   d_in      target bit
//   d_valid   d_in is valid; a push happens when d_valid && d_ready
//   d_ready   FIFO can accept (== !full)
//   hold      pause issue: no pop, {j,k}=00
//   j, k      registered excitation to the JK flop
//   q_fb      q of the driven flop, synchronous to clk
//   empty     FIFO empty
//   full      FIFO holds DEPTH entries
//   mismatch  registered one-cycle pulse when q_fb differs from expected
//   err_cnt   saturating mismatch counter
module jk_excitation_gen #(
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8,
  parameter bit TOGGLE_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             hold,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             empty,
  output logic             full,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          fifoMem [DEPTH];

  logic push;
  logic pop;
  logic target;
  logic shadow;
  logic shadowNext;
  logic jNext;
  logic kNext;

  logic exp_p1;
  logic exp_p2;
  logic vld_p1;
  logic vld_p2;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign d_ready = !full;

  // A push is refused when full, even if a pop frees a slot on the same edge.
  // The pop uses the current empty, so a bit pushed into an empty FIFO waits
  // one edge before it is issued.
  assign push   = d_valid && !full;
  assign pop    = !empty && !hold;
  assign target = fifoMem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr[AW-1:0]] <= d_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
    end
  end

  always_comb begin
    jNext      = 1'b0;
    kNext      = 1'b0;
    shadowNext = shadow;
    if (pop) begin
      shadowNext = target;
      if (target != shadow) begin
        if (TOGGLE_EN) begin
          jNext = 1'b1;
          kNext = 1'b1;
        end else begin
          jNext = target;
          kNext = !target;
        end
      end
    end
  end

  // ---- stage 1: issue {j,k}, update the shadow, capture expected q ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j      <= 1'b0;
      k      <= 1'b0;
      shadow <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      j      <= jNext;
      k      <= kNext;
      shadow <= shadowNext;
      vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    exp_p1 <= shadowNext;
  end

  // ---- stage 2: expected q aligned with the flop's update edge ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    exp_p2 <= exp_p1;
  end

  // ---- stage 3: compare against q_fb, flag and count ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      mismatch <= vld_p2 && (q_fb != exp_p2);
      if (vld_p2 && (q_fb != exp_p2)) begin
        err_cnt <= satInc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_jk_excitation_gen.sv
// Bench for jk_excitation_gen: two instances (set/reset codes and toggle
// codes) share the stimulus; each drives its own ideal JK flop model whose q
// is fed back, optionally forced to 0 to create faults.
module tb_jk_excitation_gen;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  logic d_in;
  logic d_valid;
  logic hold;
  logic fault;
  logic noMisChk;

  logic             dReady0, j0, k0, empty0, full0, mis0;
  logic             dReady1, j1, k1, empty1, full1, mis1;
  logic [CNT_W-1:0] err0, err1;
  logic             qm0, qm1;
  logic             qFb0, qFb1;

  int nVec;
  int nMis;

  assign qFb0 = fault ? 1'b0 : qm0;
  assign qFb1 = fault ? 1'b0 : qm1;

  jk_excitation_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TOGGLE_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .d_ready(dReady0),
    .hold(hold), .j(j0), .k(k0), .q_fb(qFb0), .empty(empty0), .full(full0),
    .mismatch(mis0), .err_cnt(err0)
  );

  jk_excitation_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TOGGLE_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .d_ready(dReady1),
    .hold(hold), .j(j1), .k(k1), .q_fb(qFb1), .empty(empty1), .full(full1),
    .mismatch(mis1), .err_cnt(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] jkFor(input logic t, input logic s, input bit tog);
    if (t == s) return 2'b00;
    if (tog)    return 2'b11;
    return t ? 2'b10 : 2'b01;
  endfunction

  function automatic logic jkStep(input logic q, input logic jj, input logic kk);
    case ({jj, kk})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  // Ideal downstream JK flops, reset together with the block.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qm0 <= 1'b0;
      qm1 <= 1'b0;
    end else begin
      qm0 <= jkStep(qm0, j0, k0);
      qm1 <= jkStep(qm1, j1, k1);
    end
  end

  // Scoreboard: expected codes are queued when a bit is accepted and popped
  // on the edge the model says the bit is issued.
  int         cnt;
  logic       lastT;
  logic [1:0] expQ0[$];
  logic [1:0] expQ1[$];
  logic [1:0] pend0, pend1;
  bit         doPop, doPush;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   = 0;
      lastT = 1'b0;
      expQ0.delete();
      expQ1.delete();
      pend0 = 2'b00;
      pend1 = 2'b00;
    end else begin
      doPop  = (cnt > 0) && !hold;
      doPush = d_valid && (cnt < DEPTH);
      pend0  = 2'b00;
      pend1  = 2'b00;
      if (doPop) begin
        pend0 = expQ0.pop_front();
        pend1 = expQ1.pop_front();
        cnt--;
      end
      if (doPush) begin
        expQ0.push_back(jkFor(d_in, lastT, 1'b0));
        expQ1.push_back(jkFor(d_in, lastT, 1'b1));
        lastT = d_in;
        cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checkVal("jk0", {j0, k0}, pend0);
      checkVal("jk1", {j1, k1}, pend1);
      checkVal("empty0", empty0, cnt == 0);
      checkVal("full0", full0, cnt == DEPTH);
      checkVal("d_ready0", dReady0, cnt != DEPTH);
      checkVal("empty1", empty1, cnt == 0);
      if (noMisChk) begin
        checkVal("mismatch0", mis0, 1'b0);
        checkVal("mismatch1", mis1, 1'b0);
      end
    end
  end

  logic streamBits [5];
  logic bpBits     [4];

  initial begin
    nVec = 0;
    nMis = 0;
    streamBits = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bpBits     = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b0; d_in = 1'b0; d_valid = 1'b0; hold = 1'b0;
    fault = 1'b0; noMisChk = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkVal("rst_jk0", {j0, k0}, 2'b00);
    checkVal("rst_jk1", {j1, k1}, 2'b00);
    checkVal("rst_d_ready", dReady0, 1'b1);
    checkVal("rst_empty", empty0, 1'b1);
    checkVal("rst_full", full0, 1'b0);
    checkVal("rst_err_cnt", err0, 8'd0);
    checkVal("rst_mismatch", mis0, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Back-to-back stream 1,1,0,0,1; flop q follows three negedges later
    for (int i = 0; i < 8; i++) begin
      if (i >= 3) begin
        checkVal("stream_q0", qm0, streamBits[i-3]);
        checkVal("stream_q1", qm1, streamBits[i-3]);
      end
      if (i < 5) begin
        d_valid = 1'b1;
        d_in    = streamBits[i];
      end else begin
        d_valid = 1'b0;
      end
      @(negedge clk);
    end
    checkVal("stream_err0", err0, 8'd0);
    checkVal("stream_err1", err1, 8'd0);

    // Backpressure: fill under hold, refuse a fifth push, then drain
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      d_valid = 1'b1;
      d_in    = bpBits[i];
      @(negedge clk);
    end
    checkVal("bp_full", full0, 1'b1);
    checkVal("bp_d_ready", dReady0, 1'b0);
    d_valid = 1'b1;
    d_in    = ~bpBits[DEPTH-1];
    @(negedge clk);
    d_valid = 1'b0;
    checkVal("bp_full_after_5th", full0, 1'b1);
    hold = 1'b0;
    repeat (DEPTH) @(negedge clk);
    checkVal("bp_drained_empty", empty0, 1'b1);
    repeat (3) @(negedge clk);

    // Fault: q_fb stuck at 0, push a 1
    noMisChk = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    fault = 1'b1;
    @(negedge clk);
    d_valid = 1'b1;
    d_in    = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    @(negedge clk);
    checkVal("fault_mis_a1", mis0, 1'b0);
    @(negedge clk);
    checkVal("fault_mis_a2", mis0, 1'b0);
    @(negedge clk);
    checkVal("fault_mis_a3", mis0, 1'b1);
    checkVal("fault_err_a3", err0, 8'd1);
    @(negedge clk);
    checkVal("fault_err_a4", err0, 8'd2);
    repeat (300) @(negedge clk);
    checkVal("fault_err_sat", err0, 8'd255);
    checkVal("fault_mis_sat", mis0, 1'b1);

    // Mid-operation reset with bits queued and one in flight
    fault = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    noMisChk = 1'b1;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_valid = 1'b1;
      d_in    = i[0] ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    d_valid = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkVal("mrst_empty", empty0, 1'b1);
    checkVal("mrst_jk0", {j0, k0}, 2'b00);
    checkVal("mrst_jk1", {j1, k1}, 2'b00);
    checkVal("mrst_d_ready", dReady0, 1'b1);
    checkVal("mrst_err", err0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checkVal("mrst_err0_after", err0, 8'd0);
    checkVal("mrst_err1_after", err1, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
